// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package cmp_pkg;

    // One-hot compare outcome: bit2 = A>B, bit1 = A==B, bit0 = A<B.
    typedef enum logic [2:0] {
        CMP_LT = 3'b001,
        CMP_EQ = 3'b010,
        CMP_GT = 3'b100
    } cmp_res_t;

    // Output-register occupancy.
    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } cmp_state_t;

    // Increment that sticks at max instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
        return (cnt >= max) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/mag_cmp_core.sv
// Combinational WIDTH-bit magnitude compare, unsigned or two's-complement.
module mag_cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SIGNED = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_res_t         res
);

    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;

    // Flipping the sign bit maps two's-complement onto offset binary, so one unsigned compare serves both modes.
    always_comb begin
        a_key = (SIGNED != 0) ? (a ^ MSB_MASK) : a;
        b_key = (SIGNED != 0) ? (b ^ MSB_MASK) : b;
        if (a_key > b_key) begin
            res = CMP_GT;
        end else if (a_key == b_key) begin
            res = CMP_EQ;
        end else begin
            res = CMP_LT;
        end
    end

endmodule

// File: rtl/mag_compare_seq.sv
// Pipelined magnitude comparator with valid/ready handshake and saturating statistics.
module mag_compare_seq
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       result,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] lt_count,
    output logic [CNT_W-1:0] eq_streak
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    cmp_state_t       state_q,  state_d;
    logic [2:0]       result_q, result_d;
    logic [CNT_W-1:0] gt_q,  gt_d;
    logic [CNT_W-1:0] eq_q,  eq_d;
    logic [CNT_W-1:0] lt_q,  lt_d;
    logic [CNT_W-1:0] str_q, str_d;

    logic [CNT_W-1:0] gt_base, eq_base, lt_base, str_base;
    cmp_res_t         cmp_res;
    logic             accept;

    mag_cmp_core #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_core (
        .a   (a),
        .b   (b),
        .res (cmp_res)
    );

    assign in_ready  = (state_q == ST_EMPTY) || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_FULL);
    assign result    = result_q;
    assign gt_count  = gt_q;
    assign eq_count  = eq_q;
    assign lt_count  = lt_q;
    assign eq_streak = str_q;

    // Next-state: occupancy, result capture and statistics; clear zeroes the base before any accept update.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        gt_base  = clear ? '0 : gt_q;
        eq_base  = clear ? '0 : eq_q;
        lt_base  = clear ? '0 : lt_q;
        str_base = clear ? '0 : str_q;
        gt_d     = gt_base;
        eq_d     = eq_base;
        lt_d     = lt_base;
        str_d    = str_base;

        if (accept) begin
            state_d  = ST_FULL;
            result_d = cmp_res;
            unique case (cmp_res)
                CMP_GT: begin
                    gt_d  = CNT_W'(sat_inc(32'(gt_base), 32'(CNT_MAX)));
                    str_d = '0;
                end
                CMP_EQ: begin
                    eq_d  = CNT_W'(sat_inc(32'(eq_base), 32'(CNT_MAX)));
                    str_d = CNT_W'(sat_inc(32'(str_base), 32'(CNT_MAX)));
                end
                default: begin
                    lt_d  = CNT_W'(sat_inc(32'(lt_base), 32'(CNT_MAX)));
                    str_d = '0;
                end
            endcase
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // State, result and counter registers; async reset drops any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            result_q <= '0;
            gt_q     <= '0;
            eq_q     <= '0;
            lt_q     <= '0;
            str_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
            str_q    <= str_d;
        end
    end

endmodule

// File: tb/tb_mag_compare_seq.sv
// Bench for mag_compare_seq: three configurations driven in lockstep against a behavioural model.
module tb_mag_compare_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] a = 4'h0;
    logic [3:0] b = 4'h0;
    logic       clear = 1'b0;
    logic       out_ready = 1'b1;

    int checks   = 0;
    int failures = 0;

    // Instance 0: unsigned, CNT_W=8; 1: signed, CNT_W=8; 2: unsigned, CNT_W=2
    logic       ir0, ov0, ir1, ov1, ir2, ov2;
    logic [2:0] res0, res1, res2;
    logic [7:0] gt0, eq0, lt0, st0, gt1, eq1, lt1, st1;
    logic [1:0] gt2, eq2, lt2, st2;

    mag_compare_seq #(.WIDTH(4), .SIGNED(0), .CNT_W(8)) u_uns (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b),
        .clear(clear), .out_valid(ov0), .out_ready(out_ready), .result(res0),
        .gt_count(gt0), .eq_count(eq0), .lt_count(lt0), .eq_streak(st0));

    mag_compare_seq #(.WIDTH(4), .SIGNED(1), .CNT_W(8)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
        .clear(clear), .out_valid(ov1), .out_ready(out_ready), .result(res1),
        .gt_count(gt1), .eq_count(eq1), .lt_count(lt1), .eq_streak(st1));

    mag_compare_seq #(.WIDTH(4), .SIGNED(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .a(a), .b(b),
        .clear(clear), .out_valid(ov2), .out_ready(out_ready), .result(res2),
        .gt_count(gt2), .eq_count(eq2), .lt_count(lt2), .eq_streak(st2));

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int  is_signed[3] = '{0, 1, 0};
    int  cmax[3]      = '{255, 255, 3};
    bit  mv[3]        = '{0, 0, 0};
    int  mres[3]      = '{0, 0, 0};
    int  mgt[3]       = '{0, 0, 0};
    int  meq[3]       = '{0, 0, 0};
    int  mlt[3]       = '{0, 0, 0};
    int  mstr[3]      = '{0, 0, 0};

    function automatic int to_val(int k, logic [3:0] x);
        int v;
        v = int'(x);
        if (is_signed[k] != 0 && v >= 8) v = v - 16;
        return v;
    endfunction

    function automatic int model_cmp(int k, logic [3:0] xa, logic [3:0] xb);
        int va, vb;
        va = to_val(k, xa);
        vb = to_val(k, xb);
        if (va > vb) return 4;
        if (va == vb) return 2;
        return 1;
    endfunction

    function automatic int bump(int v, int mx);
        return (v + 1 > mx) ? mx : v + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                mv[k] = 0; mres[k] = 0; mgt[k] = 0; meq[k] = 0; mlt[k] = 0; mstr[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit acc;
                int r;
                acc = in_valid && (!mv[k] || out_ready);
                if (clear) begin
                    mgt[k] = 0; meq[k] = 0; mlt[k] = 0; mstr[k] = 0;
                end
                if (acc) begin
                    r = model_cmp(k, a, b);
                    mv[k] = 1;
                    mres[k] = r;
                    if (r == 4) begin mgt[k] = bump(mgt[k], cmax[k]); mstr[k] = 0; end
                    else if (r == 2) begin meq[k] = bump(meq[k], cmax[k]); mstr[k] = bump(mstr[k], cmax[k]); end
                    else begin mlt[k] = bump(mlt[k], cmax[k]); mstr[k] = 0; end
                end else if (mv[k] && out_ready) begin
                    mv[k] = 0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int k, input logic ir, input logic ov, input logic [2:0] r,
                            input int g, input int e, input int l, input int s);
        check($sformatf("in_ready[%0d]", k),  int'(ir), int'(!mv[k] || out_ready));
        check($sformatf("out_valid[%0d]", k), int'(ov), int'(mv[k]));
        check($sformatf("result[%0d]", k),    int'(r),  mres[k]);
        check($sformatf("gt_count[%0d]", k),  g, mgt[k]);
        check($sformatf("eq_count[%0d]", k),  e, meq[k]);
        check($sformatf("lt_count[%0d]", k),  l, mlt[k]);
        check($sformatf("eq_streak[%0d]", k), s, mstr[k]);
    endtask

    always @(negedge clk) begin
        cmp_inst(0, ir0, ov0, res0, int'(gt0), int'(eq0), int'(lt0), int'(st0));
        cmp_inst(1, ir1, ov1, res1, int'(gt1), int'(eq1), int'(lt1), int'(st1));
        cmp_inst(2, ir2, ov2, res2, int'(gt2), int'(eq2), int'(lt2), int'(st2));
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic [3:0] xa, input logic [3:0] xb,
                        input logic ordy, input logic clr);
        in_valid  = v;
        a         = xa;
        b         = xb;
        out_ready = ordy;
        clear     = clr;
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("reset_out_valid", int'(ov0), 0);
        check("reset_result", int'(res0), 0);
        rst_n = 1'b1;
        step(0, 4'h0, 4'h0, 1, 0);
        check("ready_after_reset", int'(ir0), 1);

        // Compare values, 1-cycle latency
        step(1, 4'hF, 4'h1, 1, 0);
        check("uns_F_gt_1", int'(res0), 3'b100);
        check("sgn_m1_lt_1", int'(res1), 3'b001);
        step(1, 4'h3, 4'h3, 1, 0);
        check("uns_3_eq_3", int'(res0), 3'b010);
        check("sgn_3_eq_3", int'(res1), 3'b010);
        step(1, 4'h0, 4'h8, 1, 0);
        check("uns_0_lt_8", int'(res0), 3'b001);
        check("sgn_0_gt_m8", int'(res1), 3'b100);
        step(1, 4'h8, 4'h7, 1, 0);
        check("sgn_m8_lt_7", int'(res1), 3'b001);
        step(1, 4'h7, 4'h8, 1, 0);
        check("sgn_7_gt_m8", int'(res1), 3'b100);
        check("uns_gt_total", int'(gt0), 2);
        check("uns_lt_total", int'(lt0), 2);

        // Backpressure
        step(0, 4'h0, 4'h0, 1, 0);
        step(1, 4'h5, 4'h2, 0, 0);
        check("bp_first_taken", int'(res0), 3'b100);
        check("bp_ready_low", int'(ir0), 0);
        step(1, 4'h1, 4'h2, 0, 0);
        step(1, 4'h1, 4'h2, 0, 0);
        check("bp_result_held", int'(res0), 3'b100);
        check("bp_second_uncounted", int'(lt0), 2);
        step(1, 4'h1, 4'h2, 1, 0);
        check("bp_second_taken", int'(res0), 3'b001);
        check("bp_second_counted", int'(lt0), 3);

        // Saturation and streak on CNT_W=2
        step(0, 4'h0, 4'h0, 1, 1);
        repeat (5) step(1, 4'h4, 4'h4, 1, 0);
        check("sat_eq_count", int'(eq2), 3);
        check("sat_eq_streak", int'(st2), 3);
        step(1, 4'h9, 4'h2, 1, 0);
        check("sat_streak_break", int'(st2), 0);
        check("sat_gt_count", int'(gt2), 1);
        check("sat_eq_kept", int'(eq2), 3);

        // clear with simultaneous EQ accept
        step(0, 4'h0, 4'h0, 1, 1);
        step(1, 4'h5, 4'h2, 1, 0);
        step(1, 4'h5, 4'h2, 1, 0);
        step(1, 4'h4, 4'h4, 1, 0);
        step(1, 4'h4, 4'h4, 1, 0);
        step(1, 4'h1, 4'h2, 1, 0);
        step(1, 4'h1, 4'h2, 1, 0);
        check("pre_clear_gt", int'(gt2), 2);
        check("pre_clear_eq", int'(eq2), 2);
        check("pre_clear_lt", int'(lt2), 2);
        step(1, 4'h6, 4'h6, 1, 1);
        check("clracc_eq", int'(eq2), 1);
        check("clracc_gt", int'(gt2), 0);
        check("clracc_lt", int'(lt2), 0);
        check("clracc_streak", int'(st2), 1);
        check("clracc_result_kept_path", int'(res2), 3'b010);

        // Reset mid-operation with a held result
        step(1, 4'h5, 4'h2, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(ov0), 0);
        check("midrst_result", int'(res0), 0);
        check("midrst_gt", int'(gt0), 0);
        check("midrst_eq", int'(eq2), 0);
        check("midrst_streak", int'(st2), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(0, 4'h0, 4'h0, 1, 0);
        step(1, 4'hA, 4'hA, 1, 0);
        check("post_rst_eq", int'(eq0), 1);
        step(0, 4'h0, 4'h0, 1, 0);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
